multiport_sram_ctrl: RTL and testbench
======================================

MULTIPORT_SRAM_CTRL -- requirements
Module: multiport_sram_ctrl

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of requester ports (1..8).
REQ-002 SHALL have parameter NumWords, default 1<<20, SRAM depth in DataWidth words.
REQ-003 SHALL have parameter AddrWidth, default 64, byte-address width.
REQ-004 SHALL have parameter DataWidth, default 64, word width (power of two, >=16).
REQ-005 SHALL have parameter BaseAddr, default 64'h80000000, byte address of word 0.
REQ-006 SHALL have parameter ReadLatency, default 1, grant-to-response cycles (1..4).
REQ-007 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port req_i  in  NumPorts  per-port request.
REQ-010 SHALL have port gnt_o  out  NumPorts  per-port grant, one-hot or zero.
REQ-011 SHALL have port we_i  in  NumPorts  per-port write enable.
REQ-012 SHALL have port addr_i  in  NumPorts x AddrWidth  per-port byte address.
REQ-013 SHALL have port wdata_i  in  NumPorts x DataWidth  per-port write data.
REQ-014 SHALL have port be_i  in  NumPorts x DataWidth/8  per-port byte strobes.
REQ-015 SHALL have port rvalid_o  out  NumPorts  per-port response valid.
REQ-016 SHALL have port rdata_o  out  NumPorts x DataWidth  per-port read data.
REQ-017 SHALL have port err_o  out  NumPorts  per-port response error, qualified by rvalid_o.

Function
REQ-018 SHALL grant combinationally, same cycle as req_i, at most one port per cycle; access occurs on that rising edge.
REQ-019 SHALL arbitrate round-robin: search starts at pointer; after a grant to port k the pointer becomes (k+1) mod NumPorts; no grant leaves the pointer unchanged.
REQ-020 SHALL compute word index = (addr - BaseAddr) >> log2(DataWidth/8), ignoring low address bits.
REQ-021 SHALL flag out-of-range when addr < BaseAddr or index >= NumWords: no SRAM write, rdata_o zero, err_o high.
REQ-022 SHALL on a granted write update only bytes whose be_i bit is 1; be_i zero leaves memory unchanged.
REQ-023 SHALL assert rvalid_o[k] for exactly one cycle, ReadLatency cycles after each grant to port k, for reads and writes alike (write response: rdata_o zero, err_o per REQ-021).
REQ-024 SHALL return on read the word value before any same-cycle write (one grant per cycle makes this moot); a read granted after a write returns new data.
REQ-025 SHALL support back-to-back grants every cycle; response pipeline SHALL hold ReadLatency entries (port id, err, valid) with no stalls or back-pressure.
REQ-026 SHALL hold rdata_o[k] stable until the next rvalid_o[k]; outputs for non-responding ports are don't-care except rvalid_o=0.

Reset
REQ-027 SHALL on rst_ni low asynchronously clear rvalid_o, err_o, rdata_o, pointer to port 0; gnt_o is 0 while in reset.
REQ-028 SHALL drop in-flight responses on reset mid-operation; none emerge after deassertion.
REQ-029 SHALL not initialise SRAM contents on reset.

Structure
REQ-030 SHALL place strobe-to-bitmask expansion function and port-index type in shared package soc_mem_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (parameter NumPorts; req in, one-hot gnt out, pointer state inside).
REQ-032 SHALL infer the storage array as single-port synchronous SRAM.

Verification
REQ-033 SHALL test: port0 write 0x80000008 data 0x1122334455667788 be 0xFF, then read -> rvalid after ReadLatency, rdata 0x1122334455667788, err 0.
REQ-034 SHALL test: be=0x0F write 0xFFFFFFFFFFFFFFFF over 0x1122334455667788 -> read returns 0x11223344FFFFFFFF.
REQ-035 SHALL test: NumPorts=2, both req held 4 cycles -> grants 0,1,0,1; each port gets 2 responses in grant order.
REQ-036 SHALL test: read 0x7FFFFFF8 and 0x80000000+NumWords*8 -> err 1, rdata 0, memory unchanged.
REQ-037 SHALL test: ReadLatency=3, reset asserted cycle after grant -> no rvalid ever for that request; pointer back to 0.
REQ-038 SHALL test: single port, continuous reads of 8 consecutive addresses -> 8 consecutive rvalid cycles, correct data each.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// Shared types and helpers for the SoC memory subsystem.
package soc_mem_pkg;

    localparam int unsigned MaxPorts     = 8;
    localparam int unsigned MaxDataWidth = 1024;
    localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;

    typedef logic [$clog2(MaxPorts)-1:0] port_idx_t;

    // Expand byte strobes to a bit mask; callers slice off the width they need.
    function automatic logic [MaxDataWidth-1:0] be_to_mask(input logic [MaxBeWidth-1:0] be);
        logic [MaxDataWidth-1:0] mask;
        for (int unsigned b = 0; b < MaxBeWidth; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter
    import soc_mem_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o
);

    port_idx_t             r_ptr;
    port_idx_t             w_ptr_d;
    logic [NumPorts-1:0]   w_gnt;
    int unsigned           w_best;
    int unsigned           w_sel;
    int unsigned           w_dist;

    // Winner is the requester at the smallest rotational distance from the pointer.
    always_comb begin
        w_best  = NumPorts;
        w_sel   = 0;
        w_dist  = 0;
        w_gnt   = '0;
        w_ptr_d = r_ptr;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            w_dist = (i + NumPorts - 32'(r_ptr)) % NumPorts;
            if (req_i[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
            end
        end
        for (int unsigned i = 0; i < NumPorts; i++) begin
            w_gnt[i] = (w_best < NumPorts) && (i == w_sel);
        end
        if (w_best < NumPorts) begin
            w_ptr_d = port_idx_t'((w_sel + 1) % NumPorts);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end

    assign gnt_o = w_gnt & {NumPorts{rst_ni}};

endmodule

// File: rtl/multiport_sram_ctrl.sv
// Multi-port front end for a single-port synchronous SRAM with fixed-latency responses.
module multiport_sram_ctrl
    import soc_mem_pkg::*;
#(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned NumWords    = 1 << 20,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter logic [63:0] BaseAddr    = 64'h8000_0000,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    output logic [NumPorts-1:0]                 gnt_o,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts*AddrWidth-1:0]       addr_i,
    input  logic [NumPorts*DataWidth-1:0]       wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0]   be_i,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [NumPorts*DataWidth-1:0]       rdata_o,
    output logic [NumPorts-1:0]                 err_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned OffBits = $clog2(BeWidth);
    localparam int unsigned IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic [NumPorts-1:0]     w_gnt;
    port_idx_t               w_sel;
    logic                    w_any;
    logic                    w_we;
    logic [AddrWidth-1:0]    w_addr;
    logic [AddrWidth-1:0]    w_off;
    logic [AddrWidth-1:0]    w_index;
    logic [DataWidth-1:0]    w_wdata;
    logic [BeWidth-1:0]      w_be;
    logic [MaxDataWidth-1:0] w_mask_full_unused;
    logic [DataWidth-1:0]    w_mask;
    logic                    w_oor;
    logic                    w_access;
    logic [IdxW-1:0]         w_widx;

    rr_arbiter #(
        .NumPorts (NumPorts)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i),
        .gnt_o  (w_gnt)
    );

    assign gnt_o = w_gnt;
    assign w_any = |w_gnt;

    always_comb begin
        w_sel   = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (w_gnt[i]) begin
                w_sel   = port_idx_t'(i);
                w_we    = we_i[i];
                w_addr  = addr_i[i*AddrWidth +: AddrWidth];
                w_wdata = wdata_i[i*DataWidth +: DataWidth];
                w_be    = be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    assign w_off    = w_addr - AddrWidth'(BaseAddr);
    assign w_index  = w_off >> OffBits;
    assign w_oor    = (w_addr < AddrWidth'(BaseAddr)) || (w_index >= AddrWidth'(NumWords));
    assign w_access = w_any && !w_oor;
    assign w_widx   = w_index[IdxW-1:0];

    assign w_mask_full_unused = be_to_mask(MaxBeWidth'(w_be));
    assign w_mask             = w_mask_full_unused[DataWidth-1:0];

    // Storage: one access per cycle, read returns the pre-write word.
    logic [DataWidth-1:0] r_mem [NumWords];
    logic [DataWidth-1:0] r_sram_q;

    always_ff @(posedge clk_i) begin
        if (w_access) begin
            if (w_we) begin
                r_mem[w_widx] <= (r_mem[w_widx] & ~w_mask) | (w_wdata & w_mask);
            end
            r_sram_q <= r_mem[w_widx];
        end
    end

    logic [ReadLatency-1:0] r_vld;
    logic [ReadLatency-1:0] r_err;
    logic [ReadLatency-1:0] r_rd;
    port_idx_t              r_pid [ReadLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_err <= '0;
            r_rd  <= '0;
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                r_pid[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_any;
            r_err[0] <= w_oor;
            r_rd[0]  <= w_access && !w_we;
            r_pid[0] <= w_sel;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    logic [DataWidth-1:0] w_dly_out;

    // Read data leaves the SRAM one cycle after grant; extra latency is a plain delay line.
    if (ReadLatency == 1) begin : g_lat1
        assign w_dly_out = r_sram_q;
    end else begin : g_latn
        logic [DataWidth-1:0] r_dly [ReadLatency-1];
        always_ff @(posedge clk_i) begin
            r_dly[0] <= r_sram_q;
            for (int unsigned i = 1; i < ReadLatency - 1; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
        assign w_dly_out = r_dly[ReadLatency-2];
    end

    logic [DataWidth-1:0] w_resp_data;
    logic [NumPorts-1:0]  w_hit;
    logic [DataWidth-1:0] r_hold [NumPorts];

    assign w_resp_data = r_rd[ReadLatency-1] ? w_dly_out : '0;

    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            w_hit[i] = r_vld[ReadLatency-1] && (r_pid[ReadLatency-1] == port_idx_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (w_hit[i]) begin
                    r_hold[i] <= w_resp_data;
                end
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            rvalid_o[i]                      = w_hit[i];
            err_o[i]                         = w_hit[i] && r_err[ReadLatency-1];
            rdata_o[i*DataWidth +: DataWidth] = w_hit[i] ? w_resp_data : r_hold[i];
        end
    end

endmodule

// File: tb/tb_multiport_sram_ctrl.sv
// Directed plus randomized bench for multiport_sram_ctrl against a word-array reference model.
module tb_multiport_sram_ctrl;

    localparam int unsigned NP   = 2;
    localparam int unsigned NW   = 64;
    localparam int unsigned RL   = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic         clk_i  = 1'b0;
    logic         rst_ni = 1'b0;
    logic [1:0]   req;
    logic [1:0]   gnt;
    logic [1:0]   we;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [15:0]  be;
    logic [1:0]   rvalid;
    logic [127:0] rdata;
    logic [1:0]   err;

    multiport_sram_ctrl #(
        .NumPorts    (NP),
        .NumWords    (NW),
        .AddrWidth   (64),
        .DataWidth   (64),
        .BaseAddr    (BASE),
        .ReadLatency (RL)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req),
        .gnt_o    (gnt),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .be_i     (be),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned due;
        int unsigned port;
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [63:0] mem_m [NW];
    int unsigned ptr_m = 0;
    int unsigned cyc   = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  last_gnt;
    logic [1:0]  last_rv;
    logic [1:0]  last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] b);
        req[p]          = r;
        we[p]           = w;
        addr[p*64 +: 64]  = a;
        wdata[p*64 +: 64] = d;
        be[p*8 +: 8]      = b;
    endtask

    task automatic idle();
        req = 2'b00;
        we  = 2'b00;
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        sel = $urandom % 8;
        if (sel == 0) return BASE - 64'(8 * (1 + $urandom % 4)) + 64'($urandom % 8);
        if (sel == 1) return BASE + 64'(NW * 8) + 64'($urandom % 64);
        return BASE + 64'(($urandom % NW) * 8) + 64'($urandom % 8);
    endfunction

    // One cycle: check grant and responses, then apply the granted access to the model.
    task automatic tick();
        int          gi;
        logic [1:0]  eg;
        logic [1:0]  erv;
        bit          have;
        resp_t       e;
        logic [63:0] a;
        logic [63:0] old;
        int unsigned idx;
        logic        oor;
        #1;
        gi = -1;
        eg = 2'b00;
        if (rst_ni) begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = int'((ptr_m + i) % NP);
                if (gi < 0 && req[p]) gi = p;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        check("gnt", 64'(gnt), 64'(eg));
        erv  = 2'b00;
        have = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            erv[e.port] = 1'b1;
            have = 1;
        end
        check("rvalid", 64'(rvalid), 64'(erv));
        if (have) begin
            check("rdata", rdata[e.port*64 +: 64], e.data);
            check("err", 64'(err[e.port]), 64'(e.err));
        end
        last_gnt = gnt;
        last_rv  = rvalid;
        last_err = rvalid & err;
        @(posedge clk_i);
        if (gi >= 0) begin
            a   = addr[gi*64 +: 64];
            oor = (a < BASE) || (((a - BASE) >> 3) >= 64'(NW));
            idx = oor ? 0 : int'((a - BASE) >> 3);
            old = mem_m[idx];
            if (we[gi] && !oor) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[gi*8 + b]) mem_m[idx][b*8 +: 8] = wdata[gi*64 + b*8 +: 8];
                end
            end
            e.due  = cyc + RL;
            e.port = gi;
            e.data = (!we[gi] && !oor) ? old : 64'h0;
            e.err  = oor;
            exp_q.push_back(e);
            ptr_m = (gi + 1) % NP;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic drain();
        idle();
        repeat (RL + 1) tick();
    endtask

    initial begin
        logic [1:0]  g [4];
        int          c0, c1, run, best_run, errs;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;

        // Outputs and grant while reset is held.
        #2;
        req = 2'b11;
        #1;
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_rdata0", rdata[63:0], 64'h0);
        check("rst_rdata1", rdata[127:64], 64'h0);
        req = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int w = 0; w < NW; w++) begin
            drive(0, 1'b1, 1'b1, BASE + 64'(w * 8), {$urandom, $urandom}, 8'hFF);
            tick();
        end
        idle();

        // Full write then read back.
        drive(0, 1'b1, 1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF);
        tick();
        drive(0, 1'b1, 1'b0, 64'h8000_0008, 64'h0, 8'h00);
        tick();
        drain();
        check("wr_rd_data", rdata[63:0], 64'h1122334455667788);
        check("wr_rd_err", 64'(err[0]), 64'h0);

        // Partial write with low-half strobes.
        drive(0, 1'b1, 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        tick();
        drive(0, 1'b1, 1'b0, 64'h8000_0008, 64'h0, 8'h00);
        tick();
        drain();
        check("be_data", rdata[63:0], 64'h11223344FFFFFFFF);

        // Move pointer to port 0, then hold both requests four cycles.
        idle();
        drive(1, 1'b1, 1'b0, BASE + 64'h10, 64'h0, 8'h00);
        tick();
        drain();
        drive(0, 1'b1, 1'b0, BASE + 64'h8, 64'h0, 8'h00);
        drive(1, 1'b1, 1'b0, BASE + 64'h18, 64'h0, 8'h00);
        c0 = 0; c1 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            g[k] = last_gnt;
            c0 += int'(last_rv[0]);
            c1 += int'(last_rv[1]);
        end
        idle();
        for (int k = 0; k < RL + 1; k++) begin
            tick();
            c0 += int'(last_rv[0]);
            c1 += int'(last_rv[1]);
        end
        check("rr_g0", 64'(g[0]), 64'h1);
        check("rr_g1", 64'(g[1]), 64'h2);
        check("rr_g2", 64'(g[2]), 64'h1);
        check("rr_g3", 64'(g[3]), 64'h2);
        check("rr_cnt0", 64'(c0), 64'd2);
        check("rr_cnt1", 64'(c1), 64'd2);

        // Out-of-range accesses on both sides; word 0 and last word must survive.
        errs = 0;
        drive(0, 1'b1, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00);
        tick(); errs += int'(last_err[0]);
        drive(0, 1'b1, 1'b0, BASE + 64'(NW * 8), 64'h0, 8'h00);
        tick(); errs += int'(last_err[0]);
        drive(0, 1'b1, 1'b1, BASE + 64'(NW * 8), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        tick(); errs += int'(last_err[0]);
        drive(0, 1'b1, 1'b1, 64'h7FFF_FFF8, 64'hCAFE_F00D_CAFE_F00D, 8'hFF);
        tick(); errs += int'(last_err[0]);
        drive(0, 1'b1, 1'b0, BASE, 64'h0, 8'h00);
        tick(); errs += int'(last_err[0]);
        drive(0, 1'b1, 1'b0, BASE + 64'((NW - 1) * 8), 64'h0, 8'h00);
        tick(); errs += int'(last_err[0]);
        idle();
        for (int k = 0; k < RL + 1; k++) begin
            tick();
            errs += int'(last_err[0]);
        end
        check("oor_errs", 64'(errs), 64'd4);

        // Back-to-back reads of eight consecutive words.
        run = 0; best_run = 0; c0 = 0;
        for (int k = 0; k < 8 + RL + 1; k++) begin
            if (k < 8) drive(0, 1'b1, 1'b0, BASE + 64'((10 + k) * 8), 64'h0, 8'h00);
            else idle();
            tick();
            if (last_rv[0]) begin
                run++;
                c0++;
            end else begin
                run = 0;
            end
            if (run > best_run) best_run = run;
        end
        check("b2b_run", 64'(best_run), 64'd8);
        check("b2b_total", 64'(c0), 64'd8);

        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < NP; p++) begin
                drive(p, ($urandom % 4) != 0, $urandom % 2 == 1, rand_addr(),
                      {$urandom, $urandom}, 8'($urandom));
            end
            tick();
        end
        drain();

        // Reset one cycle after a grant: response is dropped, pointer returns to port 0.
        drive(0, 1'b1, 1'b0, BASE + 64'h20, 64'h0, 8'h00);
        tick();
        idle();
        rst_ni = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        #1;
        check("mid_rst_rvalid", 64'(rvalid), 64'h0);
        check("mid_rst_rdata0", rdata[63:0], 64'h0);
        req = 2'b11;
        we  = 2'b00;
        tick();
        tick();
        idle();
        rst_ni = 1'b1;
        c0 = 0;
        for (int k = 0; k < RL + 3; k++) begin
            tick();
            c0 += int'(last_rv[0]) + int'(last_rv[1]);
        end
        check("post_rst_rv", 64'(c0), 64'd0);
        drive(0, 1'b1, 1'b0, BASE + 64'h8, 64'h0, 8'h00);
        drive(1, 1'b1, 1'b0, BASE + 64'h10, 64'h0, 8'h00);
        tick();
        check("post_rst_ptr", 64'(last_gnt), 64'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
